// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/DIV/MTHI/MTLO request at a time.
// It drives the shared iterative multiply/divide unit and owns the HI/LO registers.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        unit_start,
  output logic        unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   unit_a_q, unit_a_d;
  logic [DATA_W-1:0]   unit_b_q, unit_b_d;
  logic                unit_op_q, unit_op_d;
  logic                unit_start_q, unit_start_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;
  logic                timeout_q, timeout_d;

  // Next-state and registered-output computation; pulses default low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    unit_op_d    = unit_op_q;
    unit_start_d = 1'b0;
    done_d       = 1'b0;
    div_zero_d   = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_MTHI: begin
              hi_d    = req_a;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
            OP_MTLO: begin
              lo_d    = req_a;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              // Divide-by-zero finishes immediately without touching the unit.
              if ((req_op == OP_DIV) && (req_b == '0)) begin
                div_zero_d = 1'b1;
                done_d     = 1'b1;
                state_d    = S_DONE;
              end else begin
                unit_a_d     = req_a;
                unit_b_d     = req_b;
                unit_op_d    = (req_op == OP_DIV);
                cnt_d        = '0;
                unit_start_d = 1'b1;
                state_d      = S_RUN;
              end
            end
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // unit_done in the launch cycle is stale; a real completion beats the timeout.
        if (unit_done && (cnt_q != '0)) begin
          hi_d    = unit_hi;
          lo_d    = unit_lo;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      unit_op_q    <= 1'b0;
      unit_start_q <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      unit_op_q    <= unit_op_d;
      unit_start_q <= unit_start_d;
      done_q       <= done_d;
      div_zero_q   <= div_zero_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign unit_start = unit_start_q;
  assign unit_op    = unit_op_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;
  assign div_zero   = div_zero_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench itself plays the iterative unit.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        unit_start;
  logic        unit_op;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_done;
  logic [31:0] unit_hi;
  logic [31:0] unit_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  muldiv_ctrl #(.TIMEOUT(40)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .unit_start (unit_start),
    .unit_op    (unit_op),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_done  (unit_done),
    .unit_hi    (unit_hi),
    .unit_lo    (unit_lo),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    unit_done = 1'b0;
    unit_hi   = '0;
    unit_lo   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_start", 32'(unit_start), 32'h0);
    check("rst_unit_a", unit_a, 32'h0);
    check("rst_unit_op", 32'(unit_op), 32'h0);

    // MTHI then MTLO
    request(OP_MTHI, 32'hDEADBEEF, 32'h0);
    tick();
    req_valid = 1'b0;
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_lo", lo, 32'h0);
    check("mthi_done", 32'(done), 32'h1);
    check("mthi_busy", 32'(busy), 32'h1);
    check("mthi_ready", 32'(req_ready), 32'h0);
    tick();
    check("mthi_done_clr", 32'(done), 32'h0);
    check("mthi_idle", 32'(busy), 32'h0);
    check("mthi_ready2", 32'(req_ready), 32'h1);
    request(OP_MTLO, 32'h12345678, 32'h0);
    tick();
    req_valid = 1'b0;
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_hi", hi, 32'hDEADBEEF);
    check("mtlo_done", 32'(done), 32'h1);
    tick();

    // MULT 3*5, unit completes in RUN cycle 33
    request(OP_MULT, 32'd3, 32'd5);
    tick();
    req_valid = 1'b0;
    check("mul_start", 32'(unit_start), 32'h1);
    check("mul_a", unit_a, 32'd3);
    check("mul_b", unit_b, 32'd5);
    check("mul_op", 32'(unit_op), 32'h0);
    check("mul_ready", 32'(req_ready), 32'h0);
    for (int k = 2; k <= 33; k++) begin
      tick();
      if (k == 33) begin
        unit_done = 1'b1;
        unit_hi   = 32'd0;
        unit_lo   = 32'd15;
      end
      check("mul_start_low", 32'(unit_start), 32'h0);
      check("mul_a_hold", unit_a, 32'd3);
      check("mul_b_hold", unit_b, 32'd5);
      check("mul_nodone", 32'(done), 32'h0);
    end
    tick();
    unit_done = 1'b0;
    check("mul_done", 32'(done), 32'h1);
    check("mul_hi", hi, 32'd0);
    check("mul_lo", lo, 32'd15);
    check("mul_to", 32'(timeout), 32'h0);
    check("mul_ready_done", 32'(req_ready), 32'h0);
    tick();
    check("mul_ready_back", 32'(req_ready), 32'h1);
    check("mul_done_clr", 32'(done), 32'h0);

    // Seed HI so the divide-by-zero path can show it is untouched
    request(OP_MTHI, 32'hAAAA5555, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();

    // DIV by zero
    request(OP_DIV, 32'd7, 32'd0);
    tick();
    req_valid = 1'b0;
    check("dz_done", 32'(done), 32'h1);
    check("dz_flag", 32'(div_zero), 32'h1);
    check("dz_start", 32'(unit_start), 32'h0);
    check("dz_to", 32'(timeout), 32'h0);
    check("dz_hi", hi, 32'hAAAA5555);
    check("dz_lo", lo, 32'd15);
    tick();
    check("dz_flag_clr", 32'(div_zero), 32'h0);
    check("dz_done_clr", 32'(done), 32'h0);
    check("dz_start2", 32'(unit_start), 32'h0);
    check("dz_ready", 32'(req_ready), 32'h1);

    // DIV with no response: timeout after 40 RUN cycles
    request(OP_DIV, 32'd100, 32'd7);
    tick();
    req_valid = 1'b0;
    check("to_start", 32'(unit_start), 32'h1);
    check("to_op", 32'(unit_op), 32'h1);
    check("to_a", unit_a, 32'd100);
    check("to_b", unit_b, 32'd7);
    for (int k = 2; k <= 40; k++) begin
      tick();
      check("to_wait_done", 32'(done), 32'h0);
      check("to_wait_busy", 32'(busy), 32'h1);
    end
    tick();
    check("to_done", 32'(done), 32'h1);
    check("to_flag", 32'(timeout), 32'h1);
    check("to_dz", 32'(div_zero), 32'h0);
    check("to_hi", hi, 32'hAAAA5555);
    check("to_lo", lo, 32'd15);
    tick();
    check("to_flag_clr", 32'(timeout), 32'h0);
    request(OP_MTLO, 32'h0BADF00D, 32'h0);
    tick();
    req_valid = 1'b0;
    check("post_to_lo", lo, 32'h0BADF00D);
    check("post_to_done", 32'(done), 32'h1);
    check("post_to_flag", 32'(timeout), 32'h0);
    tick();

    // Back-to-back: DIV held valid while MULT runs
    request(OP_MULT, 32'd9, 32'd4);
    tick();
    request(OP_DIV, 32'd50, 32'd6);
    check("b2b_start", 32'(unit_start), 32'h1);
    check("b2b_ready_run", 32'(req_ready), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        unit_done = 1'b1;
        unit_hi   = 32'd0;
        unit_lo   = 32'd36;
      end
      check("b2b_ready_run", 32'(req_ready), 32'h0);
      check("b2b_a_hold", unit_a, 32'd9);
      check("b2b_op_hold", 32'(unit_op), 32'h0);
    end
    tick();
    unit_done = 1'b0;
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_lo", lo, 32'd36);
    check("b2b_ready_done", 32'(req_ready), 32'h0);
    check("b2b_a_done", unit_a, 32'd9);
    tick();
    check("b2b_ready_idle", 32'(req_ready), 32'h1);
    check("b2b_a_idle", unit_a, 32'd9);
    tick();
    req_valid = 1'b0;
    check("b2b_div_start", 32'(unit_start), 32'h1);
    check("b2b_div_a", unit_a, 32'd50);
    check("b2b_div_b", unit_b, 32'd6);
    check("b2b_div_op", 32'(unit_op), 32'h1);
    tick();
    unit_done = 1'b1;
    unit_hi   = 32'd2;
    unit_lo   = 32'd8;
    tick();
    unit_done = 1'b0;
    check("b2b_div_done", 32'(done), 32'h1);
    check("b2b_div_hi", hi, 32'd2);
    check("b2b_div_lo", lo, 32'd8);
    tick();

    // Reset mid-RUN, then a stray unit_done
    request(OP_DIV, 32'd20, 32'd3);
    tick();
    req_valid = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    check("mid_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_hi", hi, 32'h0);
    check("mid_lo", lo, 32'h0);
    check("mid_start", 32'(unit_start), 32'h0);
    check("mid_ready", 32'(req_ready), 32'h1);
    tick();
    unit_done = 1'b1;
    unit_hi   = 32'hFFFF_FFFF;
    unit_lo   = 32'hFFFF_FFFF;
    tick();
    unit_done = 1'b0;
    check("stray_done", 32'(done), 32'h0);
    check("stray_hi", hi, 32'h0);
    check("stray_lo", lo, 32'h0);
    check("stray_busy", 32'(busy), 32'h0);
    tick();
    check("stray_done2", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
